// File: rtl/source_arbiter_fsm_pkg.sv
// Shared controller definitions: state encoding, LED bit positions, select-width and priority helpers.
// Combinational helpers only; no clocked logic.
package src_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COMM  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int LED_IDLE  = 0;
   localparam int LED_COMM  = 1;
   localparam int LED_WAIT  = 2;
   localparam int LED_DRAIN = 3;

   localparam int MAX_SRC = 8;

   function automatic int sel_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   // Lowest set bit wins; an all-zero vector returns 0.
   function automatic int lowest_idx(input logic [MAX_SRC-1:0] v);
      int idx;
      idx = 0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/source_arbiter_fsm_if.sv
// Button, buffer-status and producer-control signals between the arbiter and its surroundings.
// slave is the arbiter side, master the side driving buttons and buffer flags.
interface source_arbiter_fsm_if #(
   parameter int N_SRC = 2
);
   import src_ctrl_pkg::*;

   localparam int SEL_W = sel_width(N_SRC);

   logic [N_SRC-1:0] start;
   logic             stop;
   logic             buffer_full;
   logic             buffer_empty;
   logic             out_valid;
   logic [N_SRC-1:0] src_en;
   logic [SEL_W-1:0] src_sel;
   logic [3:0]       led;
   logic             busy;

   modport master (
      output start, stop, buffer_full, buffer_empty, out_valid,
      input  src_en, src_sel, led, busy
   );

   modport slave (
      input  start, stop, buffer_full, buffer_empty, out_valid,
      output src_en, src_sel, led, busy
   );

endinterface

// File: rtl/source_arbiter_fsm_btn_edge.sv
// Rising-edge detector for one raw button: two-stage register, one-cycle pulse on a 0->1 change.
// A button first sampled high at edge k pulses during the cycle after edge k.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_rise
);

   logic r_d1;
   logic r_d2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d1 <= 1'b0;
         r_d2 <= 1'b0;
      end else begin
         r_d1 <= i_btn;
         r_d2 <= r_d1;
      end
   end

   assign o_rise = r_d1 & ~r_d2;

endmodule

// File: rtl/source_arbiter_fsm.sv
// Selects one of N_SRC data producers, pauses it while the buffer is full and drains on stop.
// Define SRC_SWITCH_EN to let a start from another producer force a drain and switch to it.
module source_arbiter_fsm
   import src_ctrl_pkg::*;
#(
   parameter int N_SRC = 2
) (
   input  logic               clk,
   input  logic               rst,
   source_arbiter_fsm_if.slave bus
);

   localparam int SEL_W = sel_width(N_SRC);

   logic [N_SRC-1:0] w_start_rise;
   logic             w_stop_rise;
   logic             w_any_start;
   logic [SEL_W-1:0] w_start_low;
   logic             w_to_drain;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_sel_nxt;

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_start_edge
      btn_edge u_start_edge (
         .clk    (clk),
         .rst    (rst),
         .i_btn  (bus.start[gi]),
         .o_rise (w_start_rise[gi])
      );
   end

   btn_edge u_stop_edge (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (bus.stop),
      .o_rise (w_stop_rise)
   );

   assign w_any_start = |w_start_rise;
   assign w_start_low = SEL_W'(lowest_idx(MAX_SRC'(w_start_rise)));

`ifdef SRC_SWITCH_EN
   logic [N_SRC-1:0] w_other_rise;
   logic             w_any_other;
   logic [SEL_W-1:0] w_other_low;
   logic             r_pend_vld;
   logic             w_pend_vld_nxt;
   logic [SEL_W-1:0] r_pend_idx;
   logic [SEL_W-1:0] w_pend_idx_nxt;

   // Starts for the producer already selected never count as a switch request.
   assign w_other_rise = w_start_rise & ~(N_SRC'(1) << r_sel);
   assign w_any_other  = |w_other_rise;
   assign w_other_low  = SEL_W'(lowest_idx(MAX_SRC'(w_other_rise)));
   assign w_to_drain   = w_stop_rise | w_any_other;
`else
   assign w_to_drain   = w_stop_rise;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
`ifdef SRC_SWITCH_EN
      w_pend_vld_nxt = r_pend_vld;
      w_pend_idx_nxt = r_pend_idx;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_any_start) begin
               w_state_nxt = ST_COMM;
               w_sel_nxt   = w_start_low;
            end
         end
         ST_COMM, ST_WAIT: begin
`ifdef SRC_SWITCH_EN
            if (w_any_other) begin
               w_pend_vld_nxt = 1'b1;
               w_pend_idx_nxt = w_other_low;
            end
`endif
            if (w_to_drain) begin
               w_state_nxt = ST_DRAIN;
            end else if (r_state == ST_COMM && bus.buffer_full) begin
               w_state_nxt = ST_WAIT;
            end else if (r_state == ST_WAIT && !bus.buffer_full) begin
               w_state_nxt = ST_COMM;
            end
         end
         ST_DRAIN: begin
`ifdef SRC_SWITCH_EN
            if (w_any_start) begin
               w_pend_vld_nxt = 1'b1;
               w_pend_idx_nxt = w_start_low;
            end
            // A start arriving on the exit cycle is honoured immediately.
            if (bus.buffer_empty && !bus.out_valid) begin
               if (w_pend_vld_nxt) begin
                  w_state_nxt    = ST_COMM;
                  w_sel_nxt      = w_pend_idx_nxt;
                  w_pend_vld_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
`else
            if (bus.buffer_empty && !bus.out_valid) begin
               w_state_nxt = ST_IDLE;
            end
`endif
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

`ifdef SRC_SWITCH_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_vld <= 1'b0;
         r_pend_idx <= '0;
      end else begin
         r_pend_vld <= w_pend_vld_nxt;
         r_pend_idx <= w_pend_idx_nxt;
      end
   end
`endif

   always_comb begin
      bus.led = '0;
      case (r_state)
         ST_IDLE:  bus.led[LED_IDLE]  = 1'b1;
         ST_COMM:  bus.led[LED_COMM]  = 1'b1;
         ST_WAIT:  bus.led[LED_WAIT]  = 1'b1;
         ST_DRAIN: bus.led[LED_DRAIN] = 1'b1;
         default:  bus.led = '0;
      endcase
   end

   assign bus.src_en  = (r_state == ST_COMM) ? (N_SRC'(1) << r_sel) : '0;
   assign bus.src_sel = r_sel;
   assign bus.busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_source_arbiter_fsm.sv
// Directed bench for source_arbiter_fsm with N_SRC = 3: behavioural model checked every cycle
// plus literal expectations at key points; honours SRC_SWITCH_EN when defined.
module tb_source_arbiter_fsm;

`ifdef SRC_SWITCH_EN
   localparam bit SW = 1'b1;
`else
   localparam bit SW = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   source_arbiter_fsm_if #(.N_SRC(3)) bus ();

   source_arbiter_fsm #(.N_SRC(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: producer activity expressed as flags, not as a state register.
   bit       m_valid = 1'b0;
   bit       m_busy, m_drain, m_paused, m_pend;
   int       m_sel, m_pidx;
   bit [2:0] m_s1, m_s2;
   bit       m_p1, m_p2;

   always @(posedge clk) begin
      bit [2:0] rise;
      bit       srise;
      int       low, other_low;
      if (rst) begin
         m_busy = 0; m_drain = 0; m_paused = 0; m_pend = 0;
         m_sel = 0; m_pidx = 0;
         m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
      end else begin
         rise  = m_s1 & ~m_s2;
         srise = m_p1 & ~m_p2;
         low = -1;
         other_low = -1;
         for (int i = 0; i < 3; i++) begin
            if (rise[i] && low < 0) low = i;
            if (rise[i] && i != m_sel && other_low < 0) other_low = i;
         end
         if (!m_busy) begin
            if (low >= 0) begin
               m_busy = 1; m_sel = low; m_paused = 0; m_drain = 0;
            end
         end else if (m_drain) begin
            if (SW && low >= 0) begin
               m_pend = 1; m_pidx = low;
            end
            if (bus.buffer_empty && !bus.out_valid) begin
               m_drain = 0;
               if (SW && m_pend) begin
                  m_sel = m_pidx; m_pend = 0; m_paused = 0;
               end else begin
                  m_busy = 0;
               end
            end
         end else begin
            if (SW && other_low >= 0) begin
               m_pend = 1; m_pidx = other_low;
            end
            if (srise || (SW && other_low >= 0)) begin
               m_drain = 1; m_paused = 0;
            end else begin
               m_paused = bus.buffer_full;
            end
         end
         m_s2 = m_s1; m_s1 = bus.start;
         m_p2 = m_p1; m_p1 = bus.stop;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      logic [3:0] exp_led;
      logic [2:0] exp_en;
      if (m_valid) begin
         exp_led = !m_busy ? 4'b0001 : m_drain ? 4'b1000 : m_paused ? 4'b0100 : 4'b0010;
         exp_en  = (m_busy && !m_drain && !m_paused) ? (3'b001 << m_sel) : 3'b000;
         chk("model_led", 32'(bus.led), 32'(exp_led));
         chk("model_src_en", 32'(bus.src_en), 32'(exp_en));
         chk("model_src_sel", 32'(bus.src_sel), 32'(m_sel));
         chk("model_busy", 32'(bus.busy), 32'(m_busy));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_out(input string name, input logic [3:0] led, input logic [2:0] en,
                             input logic [1:0] sel, input logic busy);
      chk({name, "_led"}, 32'(bus.led), 32'(led));
      chk({name, "_src_en"}, 32'(bus.src_en), 32'(en));
      chk({name, "_src_sel"}, 32'(bus.src_sel), 32'(sel));
      chk({name, "_busy"}, 32'(bus.busy), 32'(busy));
   endtask

   initial begin
      bus.start = 3'b000; bus.stop = 1'b0; bus.buffer_full = 1'b0;
      bus.buffer_empty = 1'b1; bus.out_valid = 1'b0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      expect_out("reset", 4'b0001, 3'b000, 2'd0, 1'b0);

      // Two starts at once: lowest index wins, one edge after sampling.
      bus.start = 3'b110;
      tick();
      chk("start_sampled_led", 32'(bus.led), 32'h1);
      tick();
      expect_out("start_110", 4'b0010, 3'b010, 2'd1, 1'b1);
      bus.start = 3'b000;

      // Full for ten cycles pauses the producer.
      bus.buffer_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("wait_led", 32'(bus.led), 32'h4);
         chk("wait_src_en", 32'(bus.src_en), 32'h0);
      end
      bus.buffer_full = 1'b0;
      tick();
      expect_out("resume", 4'b0010, 3'b010, 2'd1, 1'b1);

      // Stop from WAIT, then drain with the consumer lagging behind.
      bus.buffer_full = 1'b1;
      tick();
      bus.stop = 1'b1;
      tick(2);
      expect_out("wait_stop", 4'b1000, 3'b000, 2'd1, 1'b1);
      bus.stop = 1'b0; bus.buffer_full = 1'b0;
      bus.buffer_empty = 1'b0; bus.out_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("drain_nonempty_led", 32'(bus.led), 32'h8);
      end
      bus.buffer_empty = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("drain_outvalid_led", 32'(bus.led), 32'h8);
      end
      bus.out_valid = 1'b0;
      tick();
      expect_out("drain_done", 4'b0001, 3'b000, 2'd1, 1'b0);

      // Stop while idle is ignored.
      bus.stop = 1'b1;
      tick(2);
      chk("idle_stop_led", 32'(bus.led), 32'h1);
      bus.stop = 1'b0;
      tick();

      // Stop rise and full together in COMM: drain, never wait.
      bus.start = 3'b001;
      tick(2);
      expect_out("start_001", 4'b0010, 3'b001, 2'd0, 1'b1);
      bus.start = 3'b000;
      bus.stop = 1'b1;
      tick();
      bus.buffer_full = 1'b1;
      tick();
      expect_out("stop_full", 4'b1000, 3'b000, 2'd0, 1'b1);
      bus.stop = 1'b0; bus.buffer_full = 1'b0;
      tick();
      chk("drain_immediate_led", 32'(bus.led), 32'h1);

      // Start for another producer while communicating.
      bus.start = 3'b001;
      tick(2);
      bus.start = 3'b000; bus.buffer_empty = 1'b0;
      tick();
      bus.start = 3'b100;
      tick(2);
`ifdef SRC_SWITCH_EN
      expect_out("switch_drain", 4'b1000, 3'b000, 2'd0, 1'b1);
      bus.start = 3'b000;
      tick();
      chk("switch_hold_led", 32'(bus.led), 32'h8);
      bus.buffer_empty = 1'b1;
      tick();
      expect_out("switch_comm", 4'b0010, 3'b100, 2'd2, 1'b1);
`else
      expect_out("no_switch", 4'b0010, 3'b001, 2'd0, 1'b1);
      bus.start = 3'b000; bus.buffer_empty = 1'b1;
      tick();
      chk("no_switch_hold_led", 32'(bus.led), 32'h2);
`endif
      bus.buffer_empty = 1'b1;
      bus.stop = 1'b1;
      tick(2);
      bus.stop = 1'b0;
      tick();
      chk("back_idle_led", 32'(bus.led), 32'h1);

      // Start pressed during a drain.
      bus.start = 3'b001;
      tick(2);
      bus.start = 3'b000; bus.buffer_empty = 1'b0; bus.stop = 1'b1;
      tick(2);
      bus.stop = 1'b0; bus.start = 3'b010;
      tick(2);
      bus.start = 3'b000; bus.buffer_empty = 1'b1;
      tick();
`ifdef SRC_SWITCH_EN
      expect_out("drain_pending", 4'b0010, 3'b010, 2'd1, 1'b1);
      bus.stop = 1'b1;
      tick(2);
      bus.stop = 1'b0;
      tick();
`else
      expect_out("drain_no_pending", 4'b0001, 3'b000, 2'd0, 1'b0);
`endif

      // Reset mid-operation with the start button held.
      bus.start = 3'b001;
      tick(2);
      chk("pre_reset_led", 32'(bus.led), 32'h2);
      rst = 1'b1;
      tick();
      expect_out("mid_reset", 4'b0001, 3'b000, 2'd0, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_reset_idle_led", 32'(bus.led), 32'h1);
      tick();
      expect_out("post_reset_comm", 4'b0010, 3'b001, 2'd0, 1'b1);
      tick(3);
      chk("held_single_rise_led", 32'(bus.led), 32'h2);
      bus.start = 3'b000;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/source_arbiter_fsm.md
SOURCE_ARBITER_FSM -- requirements
Module: source_arbiter_fsm

Interface
REQ-001 SHALL have parameter N_SRC, default 2, range 2..8: number of data producers (Fibonacci, Timer, ...).
REQ-002 SHALL have derived localparam SEL_W = max(1, clog2(N_SRC)): width of the source index.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, 100 MHz, all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  N_SRC  raw start/continue buttons, bit i = producer i.
REQ-007 stop  in  1  raw stop button for all producers.
REQ-008 buffer_full  in  1  buffer wrapper full flag, level.
REQ-009 buffer_empty  in  1  buffer wrapper empty flag, level.
REQ-010 out_valid  in  1  consumer still holds a valid word (data_2_valid), level.
REQ-011 src_en  out  N_SRC  producer enables, at most one bit high.
REQ-012 src_sel  out  SEL_W  index of the selected producer.
REQ-013 led  out  4  one-hot state: bit0 IDLE, bit1 COMM, bit2 WAIT, bit3 DRAIN.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 Every raw button SHALL pass through an edge detector: two registers d1/d2; rise = d1 & ~d2; a button first sampled high at edge k makes the FSM transition at edge k+1.
REQ-016 States SHALL be IDLE, COMM, WAIT, DRAIN; all outputs SHALL be registered or decoded from registers only.
REQ-017 IDLE: any start rise -> COMM with src_sel = lowest set index; stop rise ignored.
REQ-018 COMM: src_en[src_sel] = 1; stop rise -> DRAIN; else buffer_full -> WAIT; stop has priority over full.
REQ-019 WAIT: src_en = 0; stop rise -> DRAIN; else !buffer_full -> COMM with same src_sel.
REQ-020 DRAIN: src_en = 0; buffer_empty && !out_valid -> IDLE; src_sel held until leaving DRAIN.
REQ-021 Start rises in COMM, WAIT, DRAIN SHALL NOT change src_sel unless REQ-027 applies.
REQ-022 buffer_full and stop rise in the same cycle in COMM SHALL go to DRAIN, never WAIT.
REQ-023 DRAIN entered with buffer already empty and out_valid low SHALL exit one cycle later.

Reset
REQ-024 On rst: state IDLE, src_en 0, src_sel 0, led 4'b0001, busy 0, edge registers 0, pending cleared.
REQ-025 rst mid-operation SHALL override all transitions in that cycle; a button held through reset produces exactly one rise after release.

Configuration
REQ-026 Macro SRC_SWITCH_EN SHALL select the switch-on-the-fly feature.
REQ-027 With SRC_SWITCH_EN: a start rise for j != src_sel in COMM or WAIT SHALL latch pending = j and go to DRAIN; a start rise in DRAIN latches pending (lowest index among simultaneous, newest edge overwrites); DRAIN exit with pending set goes to COMM with src_sel = pending and clears pending.
REQ-028 Without SRC_SWITCH_EN: no pending register exists; behaviour exactly REQ-017..REQ-023.

Structure
REQ-029 State encodings, led bit indices and SEL_W function SHALL live in shared package src_ctrl_pkg.
REQ-030 Edge detection SHALL be one sub-module, btn_edge, instantiated N_SRC+1 times.

Verification (N_SRC = 3)
REQ-031 start = 3'b110 rises at edge 5 -> src_en = 3'b010, src_sel = 1, led = 4'b0010 after edge 6.
REQ-032 COMM, buffer_full 1 for 10 cycles -> WAIT, src_en 0 for those cycles, back to COMM with same src_sel when full drops.
REQ-033 WAIT, stop rise -> DRAIN; with buffer_empty 0 for 8 cycles then 1 while out_valid 1 for 2 more -> IDLE 1 cycle after out_valid falls.
REQ-034 COMM, stop rise and buffer_full in same cycle -> DRAIN, led 4'b1000.
REQ-035 SRC_SWITCH_EN, COMM src 0, start[2] rise -> DRAIN, then on drain complete COMM with src_en = 3'b100 without visiting IDLE; without macro same stimulus -> stays COMM src 0.
REQ-036 rst asserted in COMM with start[0] held high -> outputs at reset values next edge; one rise after release -> COMM src 0.
